// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and synchronous flush.
// Optional backpressure stall counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_buf #(
  parameter int unsigned    W          = 32,
  parameter logic [W-1:0]   RESET_DATA = '0,
  parameter int unsigned    CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  // Encoding is {skid_v, main_v}; ORPHAN (skid without main) is unreachable.
  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    ONE    = 2'b01,
    ORPHAN = 2'b10,
    FULL   = 2'b11
  } state_t;

  state_t         state;
  logic [W-1:0]   main_d;
  logic [W-1:0]   skid_d;
  logic           main_v;
  logic           skid_v;
  logic           accept;
  logic           drain;

  assign main_v    = state[0];
  assign skid_v    = state[1];
  assign in_ready  = ~skid_v;
  assign accept    = in_valid & in_ready;
  assign drain     = main_v & out_ready;
  assign out_valid = main_v;
  assign out_data  = main_v ? main_d : RESET_DATA;

  if (W < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipe_stage_buf: W and CNT_W must be at least 1");
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      main_d <= RESET_DATA;
      skid_d <= RESET_DATA;
    end else if (flush) begin
      state  <= EMPTY;
      main_d <= RESET_DATA;
      skid_d <= RESET_DATA;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state  <= ONE;
            main_d <= in_data;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_d <= in_data;
          end else if (accept) begin
            state  <= FULL;
            skid_d <= in_data;
          end else if (drain) begin
            state  <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state  <= ONE;
            main_d <= skid_d;
          end
        end
        ORPHAN: begin
          state  <= EMPTY;
          main_d <= RESET_DATA;
          skid_d <= RESET_DATA;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_CNT_EN
  // Saturating; deliberately untouched by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (main_v && !out_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: a W=32 instance and a W=116 all-ones-reset instance.
`timescale 1ns/1ps
module tb_pipe_stage_buf;
  localparam int unsigned   WA   = 32;
  localparam int unsigned   WB   = 116;
  localparam logic [WB-1:0] ONES = '1;
  localparam logic [WB-1:0] P5   = {29{4'h5}};
  localparam logic [WB-1:0] PA   = {29{4'hA}};

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          f0 = 1'b0, v0 = 1'b0, r0 = 1'b0;
  logic [WA-1:0] d0 = '0;
  logic          ir0, ov0;
  logic [WA-1:0] od0;

  logic          f1 = 1'b0, v1 = 1'b0, r1 = 1'b0;
  logic [WB-1:0] d1 = '0;
  logic          ir1, ov1;
  logic [WB-1:0] od1;

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] sc0;
  logic [3:0]  sc1;
`endif

  always #5 clk = ~clk;

  pipe_stage_buf #(.W(WA), .RESET_DATA(32'h0), .CNT_W(16)) u32 (
    .clk(clk), .rst(rst), .flush(f0), .in_valid(v0), .in_data(d0), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_ready(r0)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt(sc0)
`endif
  );

  pipe_stage_buf #(.W(WB), .RESET_DATA(ONES), .CNT_W(4)) u116 (
    .clk(clk), .rst(rst), .flush(f1), .in_valid(v1), .in_data(d1), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_ready(r1)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt(sc1)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: each stage is a FIFO of capacity 2 with a saturating stall count.
  logic [127:0] ment [2][2];
  int           mcnt [2]   = '{0, 0};
  int unsigned  mstall [2] = '{0, 0};
  int unsigned  msat [2]   = '{65535, 15};
  logic [127:0] acc_log [$];
  logic [127:0] del_log [$];
  logic [31:0]  cap0 [$];
  logic [31:0]  exp_list [3];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mstep(input int k, input logic f, input logic v, input logic [127:0] d,
                       input logic r);
    int n;
    n = mcnt[k];
    if (n > 0 && !r && mstall[k] < msat[k]) mstall[k]++;
    if (n > 0 && r) begin
      ment[k][0] = ment[k][1];
      n--;
    end
    if (f) n = 0;
    else if (v && mcnt[k] < 2) begin
      ment[k][n] = d;
      n++;
      if (k == 1) acc_log.push_back(d);
    end
    mcnt[k] = n;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt   = '{0, 0};
      mstall = '{0, 0};
    end else begin
      mstep(0, f0, v0, {96'b0, d0}, r0);
      mstep(1, f1, v1, {12'b0, d1}, r1);
    end
  end

  always @(negedge clk) begin
    check("ov0", 128'(ov0), 128'(mcnt[0] > 0));
    check("od0", 128'(od0), (mcnt[0] > 0) ? 128'(ment[0][0][31:0]) : 128'(0));
    check("ir0", 128'(ir0), 128'(mcnt[0] < 2));
    check("ov1", 128'(ov1), 128'(mcnt[1] > 0));
    check("od1", 128'(od1), (mcnt[1] > 0) ? 128'(ment[1][0][115:0]) : 128'(ONES));
    check("ir1", 128'(ir1), 128'(mcnt[1] < 2));
`ifdef PIPE_STALL_CNT_EN
    check("sc0", 128'(sc0), 128'(mstall[0]));
    check("sc1", 128'(sc1), 128'(mstall[1]));
`endif
    if (rst && ov0 && r0) cap0.push_back(od0);
    if (rst && ov1 && r1) del_log.push_back(128'(od1));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cap0(input string name, input int n);
    check({name, " count"}, 128'(cap0.size()), 128'(n));
    for (int i = 0; i < n && i < cap0.size(); i++)
      check({name, " item"}, 128'(cap0[i]), 128'(exp_list[i]));
  endtask

  initial begin
    void'($urandom(32'd20240611));
    repeat (2) tick;
    rst = 1'b1;
    tick;
    check("rst ov0", 128'(ov0), 128'(0));
    check("rst ir0", 128'(ir0), 128'(1));
    check("rst od1", 128'(od1), 128'(ONES));

    // 1: asynchronous reset while FULL
    r0 = 1'b0; v0 = 1'b1; d0 = 32'h1;
    tick;
    d0 = 32'h2;
    tick;
    v0 = 1'b0;
    check("t1 full ir0", 128'(ir0), 128'(0));
    check("t1 full od0", 128'(od0), 128'(32'h1));
    #2 rst = 1'b0;
    #1;
    check("t1 async ov0", 128'(ov0), 128'(0));
    check("t1 async ir0", 128'(ir0), 128'(1));
    check("t1 async od0", 128'(od0), 128'(0));
    tick;
    rst = 1'b1;
    repeat (3) tick;
    check("t1 idle ov0", 128'(ov0), 128'(0));
    check("t1 idle ir0", 128'(ir0), 128'(1));
    check("t1 idle od0", 128'(od0), 128'(0));

    // 2: streaming
    cap0.delete();
    r0 = 1'b1; v0 = 1'b1; d0 = 32'h11;
    tick;
    check("t2 od0 11", 128'(od0), 128'(32'h11));
    check("t2 ir0 a", 128'(ir0), 128'(1));
    d0 = 32'h22;
    tick;
    check("t2 od0 22", 128'(od0), 128'(32'h22));
    check("t2 ir0 b", 128'(ir0), 128'(1));
    d0 = 32'h33;
    tick;
    check("t2 od0 33", 128'(od0), 128'(32'h33));
    check("t2 ir0 c", 128'(ir0), 128'(1));
    v0 = 1'b0;
    tick;
    check("t2 empty ov0", 128'(ov0), 128'(0));
    exp_list = '{32'h11, 32'h22, 32'h33};
    check_cap0("t2 stream", 3);

    // 3: backpressure
    cap0.delete();
    r0 = 1'b0; v0 = 1'b1; d0 = 32'hA;
    tick;
    d0 = 32'hB;
    tick;
    check("t3 ir0 low", 128'(ir0), 128'(0));
    check("t3 od0 A", 128'(od0), 128'(32'hA));
    d0 = 32'hC;
    repeat (2) tick;
    check("t3 hold od0", 128'(od0), 128'(32'hA));
    check("t3 hold ir0", 128'(ir0), 128'(0));
    r0 = 1'b1;
    tick;
    check("t3 od0 B", 128'(od0), 128'(32'hB));
    check("t3 ir0 back", 128'(ir0), 128'(1));
    tick;
    check("t3 od0 C", 128'(od0), 128'(32'hC));
    v0 = 1'b0;
    tick;
    check("t3 empty ov0", 128'(ov0), 128'(0));
    exp_list = '{32'hA, 32'hB, 32'hC};
    check_cap0("t3 order", 3);

    // 4: flush priority over accept and drain
    cap0.delete();
    r0 = 1'b0; v0 = 1'b1; d0 = 32'h5;
    tick;
    d0 = 32'h6;
    tick;
    f0 = 1'b1; d0 = 32'h7; r0 = 1'b1;
    tick;
    f0 = 1'b0; v0 = 1'b0;
    check("t4 ov0", 128'(ov0), 128'(0));
    check("t4 od0", 128'(od0), 128'(0));
    check("t4 ir0", 128'(ir0), 128'(1));
    repeat (3) tick;
    check("t4 still empty", 128'(ov0), 128'(0));
    exp_list = '{32'h5, 32'h0, 32'h0};
    check_cap0("t4 drained", 1);

`ifdef PIPE_STALL_CNT_EN
    // 5: stall counter saturation, flush-insensitive, reset-cleared
    r1 = 1'b0; v1 = 1'b1; d1 = P5;
    tick;
    v1 = 1'b0;
    repeat (7) tick;
    check("t5 sc1 7", 128'(sc1), 128'(7));
    repeat (13) tick;
    check("t5 sc1 sat", 128'(sc1), 128'(15));
    f1 = 1'b1;
    tick;
    f1 = 1'b0;
    check("t5 sc1 flush", 128'(sc1), 128'(15));
    check("t5 ov1 flush", 128'(ov1), 128'(0));
    #2 rst = 1'b0;
    #1;
    check("t5 sc1 rst", 128'(sc1), 128'(0));
    tick;
    rst = 1'b1;
    tick;
`endif

    // 6: wide payload under random backpressure
    acc_log.delete();
    del_log.delete();
    for (int i = 0; i < 300; i++) begin
      v1 = 1'b1;
      d1 = (i % 2 == 0) ? P5 : PA;
      r1 = 1'($urandom_range(0, 1));
      tick;
    end
    v1 = 1'b0; r1 = 1'b1;
    repeat (4) tick;
    check("t6 nonzero", 128'(acc_log.size() > 100), 128'(1));
    check("t6 count", 128'(del_log.size()), 128'(acc_log.size()));
    for (int i = 0; i < del_log.size() && i < acc_log.size(); i++)
      check("t6 order", del_log[i], acc_log[i]);
    check("t6 idle od1", 128'(od1), 128'(ONES));
    check("t6 idle ov1", 128'(ov1), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
